// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: one column per clock. A bypass option passes the state through for
// the decrypt round that omits InvMixColumns.
module inv_mix_columns_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy,
  output logic [1:0]   fsm_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1. Valid and its
  // data stay stable until that edge. Ready never depends combinationally on valid.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic [127:0] work_q, work_d;
  logic [127:0] out_q, out_d;
  logic [127:0] mixed_w;

  logic [7:0] a [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];
  logic [7:0] b [4];

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte s[i] sits at bit 127-8i. With i = {row, col}, that bit is {~row, ~col, 3'b111}.
  function automatic logic [6:0] byte_msb(input logic [1:0] row, input logic [1:0] col);
    return {~row, ~col, 3'b111};
  endfunction

  always_comb begin
    mixed_w = work_q;
    for (int r = 0; r < 4; r++) begin
      a[r]  = work_q[byte_msb(2'(r), col_q) -: 8];
      x2[r] = xtime(a[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
      m9[r] = x8[r] ^ a[r];
      mb[r] = x8[r] ^ x2[r] ^ a[r];
      md[r] = x8[r] ^ x4[r] ^ a[r];
      me[r] = x8[r] ^ x4[r] ^ x2[r];
    end
    b[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    b[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    b[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    b[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    for (int r = 0; r < 4; r++) begin
      mixed_w[byte_msb(2'(r), col_q) -: 8] = b[r];
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    work_d  = work_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = state_in;
          if (bypass) begin
            state_d = DONE;
            out_d   = state_in;
          end else begin
            state_d = MIX;
            col_d   = 2'd0;
          end
        end
      end
      MIX: begin
        work_d = mixed_w;
        col_d  = col_q + 2'd1;
        if (col_q == 2'd3) begin
          state_d = DONE;
          out_d   = mixed_w;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      work_q  <= 128'h0;
      out_q   <= 128'h0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      work_q  <= work_d;
      out_q   <= out_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign state_out   = out_q;
  assign fsm_state_o = state_q;

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Bench for inv_mix_columns_iter: a latency-level reference model checked every cycle, a result
// scoreboard, directed known vectors and a random forward/inverse round trip.
module tb_inv_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  localparam logic [127:0] KV_IN   = 128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc;
  localparam logic [127:0] KV_EXP  = 128'hdbdbdbdb_13131313_53535353_45454545;
  localparam logic [127:0] COL_IN  = 128'h9f8e01c6_dc4d01c6_58a101c6_9dbc01c6;
  localparam logic [127:0] COL_EXP = 128'hf2db01c6_0a1301c6_225301c6_5c4501c6;
  localparam logic [127:0] BYP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

  inv_mix_columns_iter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .state_in    (state_in),
    .bypass      (bypass),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .state_out   (state_out),
    .busy        (busy),
    .fsm_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix product on each column; column c holds bytes s[c], s[c+4], s[c+8], s[c+12].
  function automatic logic [127:0] mix(input logic [127:0] s, input logic inverse);
    logic [7:0]   row0 [4];
    logic [7:0]   acc;
    logic [127:0] res;
    if (inverse) begin
      row0[0] = 8'h0e; row0[1] = 8'h0b; row0[2] = 8'h0d; row0[3] = 8'h09;
    end else begin
      row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
    end
    res = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(row0[(k - r + 4) % 4], s[127 - 8 * (c + 4 * k) -: 8]);
        res[127 - 8 * (c + 4 * r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks an outstanding transaction by age and latency only.
  logic         mdl_busy = 1'b0;
  int           mdl_age  = 0;
  int           mdl_lat  = 0;
  logic [127:0] mdl_pend = 128'h0;
  logic [127:0] mdl_out  = 128'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy = 1'b0;
      mdl_age  = 0;
      mdl_lat  = 0;
      mdl_pend = 128'h0;
      mdl_out  = 128'h0;
    end else if (!mdl_busy) begin
      if (in_valid) begin
        mdl_busy = 1'b1;
        mdl_age  = 1;
        mdl_lat  = bypass ? 1 : 5;
        mdl_pend = bypass ? state_in : mix(state_in, 1'b1);
        if (mdl_lat == 1) mdl_out = mdl_pend;
      end
    end else if (mdl_age >= mdl_lat) begin
      if (out_ready) mdl_busy = 1'b0;
    end else begin
      mdl_age++;
      if (mdl_age == mdl_lat) mdl_out = mdl_pend;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", 128'(in_ready), 128'(!mdl_busy));
    chk("out_valid", 128'(out_valid), 128'(mdl_busy && mdl_age >= mdl_lat));
    chk("busy", 128'(busy), 128'(mdl_busy));
    chk("state_out", state_out, mdl_out);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 128'(1), 128'(0));
      else chk("scoreboard", state_out, exp_q.pop_front());
    end
  end

  task automatic send(input logic [127:0] d, input logic b, input logic [127:0] exp,
                      input int exp_lat);
    int cyc;
    cyc      = 0;
    in_valid = 1'b1;
    state_in = d;
    bypass   = b;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("send_wait_ready", 128'(cyc < 50), 128'(1));
    exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 128'(cyc), 128'(exp_lat));
  endtask

  initial begin
    logic [127:0] orig;
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = 128'h0;
    bypass    = 1'b0;

    chk("model_known_vector", mix(KV_IN, 1'b1), KV_EXP);
    chk("model_columns", mix(COL_IN, 1'b1), COL_EXP);
    chk("model_forward", mix(COL_EXP, 1'b0), COL_IN);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_state_out", state_out, 128'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    send(KV_IN, 1'b0, KV_EXP, 5);
    send(COL_IN, 1'b0, COL_EXP, 5);
    send(BYP_IN, 1'b1, BYP_IN, 1);
    @(posedge clk); #1;

    out_ready = 1'b0;
    send(KV_IN, 1'b0, KV_EXP, 5);
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_state_out", state_out, KV_EXP);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));

    in_valid = 1'b1;
    state_in = KV_IN;
    bypass   = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 128'(out_valid), 128'(0));
    chk("abort_state_out", state_out, 128'h0);
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(COL_IN, 1'b0, COL_EXP, 5);

    for (int n = 0; n < 1000; n++) begin
      orig = {$urandom, $urandom, $urandom, $urandom};
      cyc  = 0;
      while (!in_ready && cyc < 50) begin
        in_valid  = 1'b1;
        state_in  = {$urandom, $urandom, $urandom, $urandom};
        bypass    = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
        cyc++;
      end
      chk("rand_wait_ready", 128'(cyc < 50), 128'(1));
      in_valid = 1'b1;
      state_in = mix(orig, 1'b0);
      bypass   = 1'b0;
      exp_q.push_back(orig);
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 in_valid  input  1  upstream holds a state word for acceptance.
REQ-004 in_ready  output  1  block can accept a state word this cycle.
REQ-005 state_in  input  128  AES state; byte s[i] = state_in[127-8i -: 8].
REQ-006 bypass  input  1  sampled with state_in; 1 = pass the state through unchanged (decrypt round that omits InvMixColumns).
REQ-007 out_valid  output  1  state_out holds a finished result.
REQ-008 out_ready  input  1  downstream takes the result this cycle.
REQ-009 state_out  output  128  result state, same byte ordering as state_in.
REQ-010 busy  output  1  high in every state other than IDLE.

Function
REQ-011 The FSM SHALL have three states:
- IDLE: in_ready=1.
- MIX: one column per cycle, 2-bit column counter col.
- DONE: out_valid=1.
REQ-012 An input is accepted on a rising edge where in_valid=1 and in_ready=1. On that edge state_in and bypass SHALL be latched into internal registers.
REQ-013 On acceptance with bypass=0: the next state is MIX and col is set to 0.
REQ-014 On acceptance with bypass=1: the next state is DONE and state_out equals the latched state_in, so out_valid rises one edge after acceptance.
REQ-015 On each MIX edge, the block SHALL compute column col from bytes (a0,a1,a2,a3) = (s[col], s[col+4], s[col+8], s[col+12]) and write the results back to the same byte positions of the result register.
REQ-016 The column transform SHALL be:
- b0 = 0E·a0 ^ 0B·a1 ^ 0D·a2 ^ 09·a3
- b1 = 09·a0 ^ 0E·a1 ^ 0B·a2 ^ 0D·a3
- b2 = 0D·a0 ^ 09·a1 ^ 0E·a2 ^ 0B·a3
- b3 = 0B·a0 ^ 0D·a1 ^ 09·a2 ^ 0E·a3
REQ-017 Multiplication SHALL be in GF(2^8) with reduction polynomial 0x11B; xtime(b) = {b[6:0],0} ^ (0x1B if b[7]).
REQ-018 After the col=3 edge the FSM SHALL enter DONE. out_valid therefore rises 5 edges after the accepting edge: 1 accept edge plus 4 column edges.
REQ-019 In DONE, state_out and out_valid SHALL hold stable until an edge with out_ready=1. That edge returns the FSM to IDLE.
REQ-020 in_ready SHALL be 0 in MIX and DONE. in_valid, state_in and bypass are ignored outside IDLE.
REQ-021 state_out SHALL change only on the edge that enters DONE. state_out is registered with no combinational path from any input.
REQ-022 If out_ready=1 while out_valid=0, the block SHALL take no action.
REQ-023 Throughput SHALL be one state per 6 cycles for bypass=0 and one state per 2 cycles for bypass=1, given out_ready tied high.
REQ-024 Round-trip property: a state passed through the team's forward MixColumns, then through this block with bypass=0, SHALL be returned unchanged.

Reset
REQ-025 While rst_n=0, the block SHALL force:
- FSM = IDLE, col = 0
- in_ready = 1, out_valid = 0, busy = 0
- state_out = 128'h0, all internal registers = 0
REQ-026 Asserting reset in MIX or DONE SHALL abort the operation immediately. The partial result is discarded and never appears with out_valid=1.
REQ-027 The first edge after rst_n deasserts SHALL be able to accept an input.

Verification
REQ-028 Known vector: state_in=128'h8e8e8e8e_4d4d4d4d_a1a1a1a1_bcbcbcbc, bypass=0 -> after 5 edges out_valid=1 and state_out=128'hdbdbdbdb_13131313_53535353_45454545.
REQ-029 Per-column independence: columns loaded with (9f,dc,58,9d), (8e,4d,a1,bc), (01,01,01,01), (c6,c6,c6,c6) -> result columns are (f2,0a,22,5c), (db,13,53,45), (01,01,01,01), (c6,c6,c6,c6) in their respective positions.
REQ-030 Bypass: state_in=128'h00112233_44556677_8899aabb_ccddeeff, bypass=1 -> state_out equals state_in with out_valid high one edge after acceptance.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and state_out stay stable and in_ready=0 throughout. The out_ready=1 edge gives in_ready=1 in the next cycle.
REQ-032 Reset mid-operation: drop rst_n during col=2 -> out_valid=0 and state_out=0 at once. A new vector after reset completes correctly in 5 edges.
REQ-033 Random round-trip: 1000 random states through the reference forward MixColumns model and then this block -> output equals the original state in every case, and in_valid presented outside IDLE is never accepted.
